// File: rtl/aes_arb_pkg.sv
// Shared constants and types for the two-requester AES core arbiter.
package aes_arb_pkg;

  localparam int AES_BLK_W     = 128;
  localparam int LAT_DEFAULT   = 21;
  localparam int TAG_W_DEFAULT = 4;

  // Tag-line entry field widths: {vld, id, tag}
  localparam int ENT_VLD_W = 1;
  localparam int ENT_ID_W  = 1;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

endpackage

// File: rtl/aes_req_arbiter_tagline.sv
// LATENCY-deep shift line of {vld, id, tag} entries; clr discards every in-flight entry.
module aes_arb_tagline
  import aes_arb_pkg::*;
#(
  parameter int LATENCY = LAT_DEFAULT,
  parameter int TAG_W   = TAG_W_DEFAULT
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                in_vld,
  input  logic [ENT_ID_W-1:0] in_id,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_vld,
  output logic [ENT_ID_W-1:0] out_id,
  output logic [TAG_W-1:0]    out_tag,
  output logic                any_vld
);

  logic [LATENCY-1:0] vld_line;
  logic [ENT_ID_W-1:0] id_line  [LATENCY];
  logic [TAG_W-1:0]    tag_line [LATENCY];

  always_ff @(posedge clk) begin
    if (clr) begin
      vld_line <= '0;
    end else begin
      vld_line[0] <= in_vld;
      for (int i = 1; i < LATENCY; i++) vld_line[i] <= vld_line[i-1];
    end
  end

  // id/tag are qualified by vld, so they shift freely without reset
  always_ff @(posedge clk) begin
    id_line[0]  <= in_id;
    tag_line[0] <= in_tag;
    for (int i = 1; i < LATENCY; i++) begin
      id_line[i]  <= id_line[i-1];
      tag_line[i] <= tag_line[i-1];
    end
  end

  assign out_vld = vld_line[LATENCY-1];
  assign out_id  = id_line[LATENCY-1];
  assign out_tag = tag_line[LATENCY-1];
  assign any_vld = |vld_line;

endmodule

// File: rtl/aes_req_arbiter.sv
// Round-robin sharing of one pipelined aes_128 core between two requesters.
// Optional performance counters are enabled with `define AES_ARB_PERF_CNT_EN.
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int LATENCY = LAT_DEFAULT,
  parameter int TAG_W   = TAG_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [AES_BLK_W-1:0] req0_key,
  input  logic [TAG_W-1:0]     req0_tag,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [AES_BLK_W-1:0] req1_key,
  input  logic [TAG_W-1:0]     req1_tag,
  output logic                 rsp0_valid,
  output logic                 rsp1_valid,
  output logic [AES_BLK_W-1:0] rsp_data,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic [AES_BLK_W-1:0] core_key,
  input  logic [AES_BLK_W-1:0] core_out,
  output logic                 busy
`ifdef AES_ARB_PERF_CNT_EN
  ,
  output logic [31:0]          issue_cnt0,
  output logic [31:0]          issue_cnt1,
  output logic [31:0]          stall_cnt
`endif
);

  logic    rr_ptr;
  logic    grant0, grant1;
  logic    hs0, hs1, hs;
  req_id_e win_id;

  logic                last_vld;
  logic [ENT_ID_W-1:0] last_id;
  logic [TAG_W-1:0]    last_tag;
  logic                line_busy;

  // A lone requester always wins; on a tie rr_ptr decides
  assign grant0 = req0_valid & (~req1_valid | (rr_ptr == REQ0));
  assign grant1 = req1_valid & (~req0_valid | (rr_ptr == REQ1));

  assign req0_ready = grant0 & ~rst;
  assign req1_ready = grant1 & ~rst;

  assign hs0    = req0_valid & req0_ready;
  assign hs1    = req1_valid & req1_ready;
  assign hs     = hs0 | hs1;
  assign win_id = hs1 ? REQ1 : REQ0;

  // Issue stage: register key into the core and advance the round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= 1'b0;
      core_key <= '0;
    end else if (hs) begin
      rr_ptr   <= ~win_id;
      core_key <= hs1 ? req1_key : req0_key;
    end
  end

  aes_arb_tagline #(
    .LATENCY (LATENCY),
    .TAG_W   (TAG_W)
  ) u_tagline (
    .clk     (clk),
    .clr     (rst),
    .in_vld  (hs),
    .in_id   (win_id),
    .in_tag  (hs1 ? req1_tag : req0_tag),
    .out_vld (last_vld),
    .out_id  (last_id),
    .out_tag (last_tag),
    .any_vld (line_busy)
  );

  // Response stage: capture the core result aligned with the last tag-line entry
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_data   <= '0;
      rsp_tag    <= '0;
    end else begin
      rsp0_valid <= last_vld & (last_id == REQ0);
      rsp1_valid <= last_vld & (last_id == REQ1);
      if (last_vld) begin
        rsp_data <= core_out;
        rsp_tag  <= last_tag;
      end
    end
  end

  assign busy = line_busy | rsp0_valid | rsp1_valid;

`ifdef AES_ARB_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt0 <= '0;
      issue_cnt1 <= '0;
      stall_cnt  <= '0;
    end else begin
      if (hs0) issue_cnt0 <= sat_inc(issue_cnt0);
      if (hs1) issue_cnt1 <= sat_inc(issue_cnt1);
      if ((req0_valid & ~req0_ready) | (req1_valid & ~req1_ready))
        stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Randomized bench for aes_req_arbiter against a queue-based response model and a delay-line core stub.
module tb_aes_req_arbiter;

  localparam int LAT = 21;
  localparam int TW  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req0_valid = 1'b0, req1_valid = 1'b0;
  logic           req0_ready, req1_ready;
  logic [127:0]   req0_key = '0, req1_key = '0;
  logic [TW-1:0]  req0_tag = '0, req1_tag = '0;
  logic           rsp0_valid, rsp1_valid;
  logic [127:0]   rsp_data;
  logic [TW-1:0]  rsp_tag;
  logic [127:0]   core_key, core_out;
  logic           busy;
`ifdef AES_ARB_PERF_CNT_EN
  logic [31:0]    issue_cnt0, issue_cnt1, stall_cnt;
`endif

  always #5 clk = ~clk;

  aes_req_arbiter #(.LATENCY(LAT), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_key   (req0_key),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_key   (req1_key),
    .req1_tag   (req1_tag),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .core_key   (core_key),
    .core_out   (core_out),
    .busy       (busy)
`ifdef AES_ARB_PERF_CNT_EN
    ,
    .issue_cnt0 (issue_cnt0),
    .issue_cnt1 (issue_cnt1),
    .stall_cnt  (stall_cnt)
`endif
  );

  // Core stub: the requester key reappears on core_out LATENCY cycles after its handshake
  logic [127:0] stub [LAT-1];
  always @(posedge clk) begin
    stub[0] <= core_key;
    for (int i = 1; i < LAT - 1; i++) stub[i] <= stub[i-1];
  end
  assign core_out = stub[LAT-2];

  typedef struct {
    int           due;
    bit           id;
    logic [TW-1:0] tag;
    logic [127:0] data;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  bit   prio = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic step(input logic v0, input logic [127:0] k0, input logic [TW-1:0] t0,
                      input logic v1, input logic [127:0] k1, input logic [TW-1:0] t1,
                      input logic r);
    bit   e0, e1, g0, g1, exp_busy;
    exp_t h;
    @(negedge clk);
    cyc++;
    e0 = 1'b0;
    e1 = 1'b0;
    exp_busy = (q.size() != 0);
    if (q.size() != 0 && q[0].due == cyc) begin
      h  = q.pop_front();
      e0 = !h.id;
      e1 = h.id;
    end
    check_val("rsp0_valid", rsp0_valid, e0);
    check_val("rsp1_valid", rsp1_valid, e1);
    check_val("busy", busy, exp_busy);
    if (e0 || e1) begin
      check_val("rsp_tag", rsp_tag, h.tag);
      check_val("rsp_data", rsp_data, h.data);
    end

    rst = r;
    req0_valid = v0; req0_key = k0; req0_tag = t0;
    req1_valid = v1; req1_key = k1; req1_tag = t1;
    #1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!r) begin
      if (v0 && v1) begin
        g0 = !prio;
        g1 = prio;
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
    check_val("req0_ready", req0_ready, g0);
    check_val("req1_ready", req1_ready, g1);
    if (r) begin
      q.delete();
      prio = 1'b0;
    end else if (g0 || g1) begin
      h.due  = cyc + LAT + 1;
      h.id   = g1;
      h.tag  = g1 ? t1 : t0;
      h.data = g1 ? k1 : k0;
      q.push_back(h);
      prio = g0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  function automatic logic [127:0] rnd_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    // Reset with req0 asking: it must never see ready
    for (int i = 0; i < 3; i++) step(1'b1, rnd_key(), 4'd5, 1'b0, '0, '0, 1'b1);
    check_val("core_key_rst", core_key, '0);
    check_val("rsp_data_rst", rsp_data, '0);
    check_val("rsp_tag_rst", {124'd0, rsp_tag}, '0);

    // Single request
    step(1'b1, 128'h000102030405060708090a0b0c0d0e0f, 4'd3, 1'b0, '0, '0, 1'b0);
    idle(LAT + 3);

    // Contention from a fresh reset
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    for (int k = 0; k < 8; k++)
      step(1'b1, rnd_key(), TW'(k), 1'b1, rnd_key(), TW'(k), 1'b0);
    idle(LAT + 3);
`ifdef AES_ARB_PERF_CNT_EN
    check_val("issue_cnt0", issue_cnt0, 32'd4);
    check_val("issue_cnt1", issue_cnt1, 32'd4);
    check_val("stall_cnt", stall_cnt, 32'd8);
`endif

    // req1 streaming alone
    for (int k = 0; k < 30; k++)
      step(1'b0, '0, '0, 1'b1, rnd_key(), TW'(k), 1'b0);
    idle(LAT + 3);

    // Reset while operations are in flight
    for (int k = 0; k < 5; k++)
      step(1'b1, rnd_key(), TW'(k + 9), 1'b0, '0, '0, 1'b0);
    idle(5);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    idle(LAT + 5);

    // Random traffic with gaps and dropped valids
    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 9) < 4, rnd_key(), TW'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 4, rnd_key(), TW'($urandom_range(0, 15)), 1'b0);
    idle(LAT + 3);
    check_val("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
